// File: rtl/sd_target64_pkg.sv
// ============================================================================
// Module   : sd_target64_pkg
// Brief    : Shared constants for the 64-bit srdy/drdy scoreboard target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_target64_pkg;

    localparam int LINE_W = 64;
    localparam int CNT_W  = 4;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sd_line_ram64.sv
// ============================================================================
// Module   : sd_line_ram64
// Brief    : 2**ASZ x 64 line store, bit-masked write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_line_ram64
    import sd_target64_pkg::*;
#(
    parameter int ASZ = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ASZ-1:0]    i_waddr,
    input  logic [LINE_W-1:0] i_wmask,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic [ASZ-1:0]    i_raddr,
    output logic [LINE_W-1:0] o_rdata
);

    // Contents deliberately have no reset so lines survive a target reset.
    logic [LINE_W-1:0] r_mem [0:(1<<ASZ)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sd_target64.sv
// ============================================================================
// Module   : sd_target64
// Brief    : z2s/s2z responder: masked line writes, whole-line delayed reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_target64
    import sd_target64_pkg::*;
#(
    parameter int s_asz  = 11,
    parameter int rd_lat = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              z2s_srdy,
    output logic              z2s_drdy,
    input  logic              z2s_req_type,
    input  logic [LINE_W-1:0] z2s_mask,
    input  logic [LINE_W-1:0] z2s_data,
    input  logic [s_asz-1:0]  z2s_itemid,
    output logic              s2z_srdy,
    input  logic              s2z_drdy,
    output logic [LINE_W-1:0] s2z_data
);

    localparam logic [CNT_W-1:0] c_RD_LAT    = CNT_W'(rd_lat);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(1);
    localparam logic             c_ZERO_LAT  = (rd_lat == 0);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [s_asz-1:0]  r_raddr;
    logic [s_asz-1:0]  w_ram_raddr;
    logic [LINE_W-1:0] w_ram_rdata;
    logic [LINE_W-1:0] r_rdata;
    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic              w_load;

    assign w_acc = z2s_srdy & z2s_drdy;
    assign w_wr  = w_acc & (z2s_req_type == REQ_WR);
    assign w_rd  = w_acc & (z2s_req_type == REQ_RD);

    // Zero-latency reads load straight from the accepted itemid.
    assign w_load      = c_ZERO_LAT ? w_rd : ((r_state == S_WAIT) && (r_cnt == c_CNT_LAST));
    assign w_ram_raddr = (r_state == S_IDLE) ? z2s_itemid : r_raddr;

    sd_line_ram64 #(
        .ASZ (s_asz)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (z2s_itemid),
        .i_wmask (z2s_mask),
        .i_wdata (z2s_data),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_rd) w_next = c_ZERO_LAT ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == c_CNT_LAST) w_next = S_RESP;
            S_RESP: if (s2z_drdy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        z2s_drdy = (r_state == S_IDLE);
        s2z_srdy = (r_state == S_RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_raddr <= '0;
            r_rdata <= '0;
        end else begin
            if (w_rd) begin
                r_raddr <= z2s_itemid;
                r_cnt   <= c_RD_LAT;
            end else if (r_state == S_WAIT) begin
                r_cnt   <= r_cnt - c_CNT_LAST;
            end
            if (w_load) begin
                r_rdata <= w_ram_rdata;
            end
        end
    end

    assign s2z_data = r_rdata;

endmodule

`default_nettype wire
